pmp_check_pipe: RTL and testbench

Multi-requester, pipelined physical memory protection checker. It arbitrates up to NUM_CH access requests (instruction fetch, load, store/AMO) into one shared two-stage pipeline and decodes them against all PMP entries in OFF/TOR/NA4/NAPOT modes. It returns a tagged fault/permit response through a valid/ready handshake. It sits between the MMU request sources and the bus-side access-fault logic, replacing per-port combinational PMP checks.

---
 rtl/pmp_check_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_pmp_check_pipe.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_check_pipe.sv
// Round-robin arbitrated PMP checker: S1 match, S2 winner/permission, registered response.
// Define PMP_FAULT_LOG_EN to add the FaultAddr/FaultCnt fault log outputs.
module pmp_check_pipe #(
    parameter int unsigned PA_BITS     = 56,
    parameter int unsigned PMP_ENTRIES = 16,
    parameter int unsigned NUM_CH      = 2,
    parameter logic [1:0]  M_MODE      = 2'b11
) (
    input  logic                                                         clk,
    input  logic                                                         reset,
    input  logic [NUM_CH-1:0]                                            ReqValid,
    output logic [NUM_CH-1:0]                                            ReqReady,
    input  logic [NUM_CH*PA_BITS-1:0]                                    ReqAddr,
    input  logic [NUM_CH*2-1:0]                                          ReqPriv,
    input  logic [NUM_CH*2-1:0]                                          ReqType,
    input  logic [((PMP_ENTRIES > 0) ? PMP_ENTRIES : 1)*8-1:0]           PMPCfg,
    input  logic [((PMP_ENTRIES > 0) ? PMP_ENTRIES : 1)*(PA_BITS-2)-1:0] PMPAdr,
    output logic                                                         RspValid,
    input  logic                                                         RspReady,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]               RspCh,
    output logic                                                         RspFault,
    output logic                                                         RspHit,
    output logic [5:0]                                                   RspIdx
`ifdef PMP_FAULT_LOG_EN
    ,
    output logic [PA_BITS-1:0]                                           FaultAddr,
    output logic [15:0]                                                  FaultCnt
`endif
);

    localparam int unsigned AW = PA_BITS - 2;
    localparam int unsigned NE = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1;
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CW-1:0]      ptr_q, ptr_d, grant;
    logic               gnt_any, accept, s1_ready, s2_ready, out_ready;
    logic [PA_BITS-1:0] req_addr;
    logic [1:0]         req_priv, req_type;

    logic               s1_valid_q, s2_valid_q, rsp_valid_q;
    logic [PA_BITS-1:0] s1_addr_q;
    logic [1:0]         s1_priv_q, s1_type_q, s2_priv_q, s2_type_q;
    logic [CW-1:0]      s1_ch_q, s2_ch_q, rsp_ch_q;
    logic               s2_hit_q, rsp_hit_q, rsp_fault_q;
    logic [5:0]         s2_idx_q, rsp_idx_q;
    logic [3:0]         s2_lxwr_q;

    assign out_ready = !rsp_valid_q || RspReady;
    assign s2_ready  = !s2_valid_q || out_ready;
    assign s1_ready  = !s1_valid_q || s2_ready;
    assign accept    = gnt_any && s1_ready;

    // Round-robin: lowest requesting channel at or above the pointer, else lowest overall
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ReqValid[c]) begin
                grant   = CW'(c);
                gnt_any = 1'b1;
            end
        end
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ReqValid[c] && (CW'(c) >= ptr_q)) grant = CW'(c);
        end
    end

    always_comb begin
        ReqReady = '0;
        req_addr = '0;
        req_priv = '0;
        req_type = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ReqReady[c] = accept && (CW'(c) == grant);
            if (CW'(c) == grant) begin
                req_addr = ReqAddr[c*PA_BITS +: PA_BITS];
                req_priv = ReqPriv[c*2 +: 2];
                req_type = ReqType[c*2 +: 2];
            end
        end
        ptr_d = ptr_q;
        if (accept) ptr_d = (grant == CW'(NUM_CH - 1)) ? '0 : grant + CW'(1);
    end

    logic [AW-1:0] s1_pa;
    logic [NE-1:0] match;
    assign s1_pa = s1_addr_q[PA_BITS-1:2];

    if (PMP_ENTRIES == 0) begin : g_none
        assign match = '0;
    end else begin : g_match
        for (genvar i = 0; i < PMP_ENTRIES; i++) begin : g_ent
            logic [AW-1:0] adr, lo, nmask;
            logic [1:0]    mode;
            logic          tor_m, na4_m, napot_m;
            assign adr  = PMPAdr[i*AW +: AW];
            assign mode = PMPCfg[i*8+3 +: 2];
            if (i == 0) begin : g_lo0
                assign lo = '0;
            end else begin : g_lo
                assign lo = PMPAdr[(i-1)*AW +: AW];
            end
            // NAPOT don't-care bits: trailing ones plus the first zero above them
            assign nmask    = adr ^ (adr + AW'(1));
            assign tor_m    = (s1_pa >= lo) && (s1_pa < adr);
            assign na4_m    = (s1_pa == adr);
            assign napot_m  = ((s1_pa ^ adr) & ~nmask) == '0;
            assign match[i] = (mode == 2'd1) ? tor_m :
                              (mode == 2'd2) ? na4_m :
                              (mode == 2'd3) ? napot_m : 1'b0;
        end
    end

    logic       win_hit;
    logic [5:0] win_idx;
    logic [3:0] win_lxwr;

    always_comb begin
        win_hit  = 1'b0;
        win_idx  = '0;
        win_lxwr = '0;
        for (int i = int'(PMP_ENTRIES) - 1; i >= 0; i--) begin
            if (match[i]) begin
                win_hit  = 1'b1;
                win_idx  = 6'(i);
                win_lxwr = {PMPCfg[i*8+7], PMPCfg[i*8 +: 3]};
            end
        end
    end

    logic perm, enforce, s2_fault;

    always_comb begin
        perm     = 1'b0;
        enforce  = 1'b0;
        s2_fault = 1'b0;
        case (s2_type_q)
            2'b01:   perm = s2_lxwr_q[1];
            2'b10:   perm = s2_lxwr_q[2];
            default: perm = s2_lxwr_q[0];
        endcase
        enforce = (s2_priv_q != M_MODE) || (s2_hit_q && s2_lxwr_q[3]);
        if (s2_hit_q) s2_fault = enforce && !perm;
        else          s2_fault = (PMP_ENTRIES > 0) && (s2_priv_q != M_MODE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_priv_q   <= '0;
            s1_type_q   <= '0;
            s1_ch_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_hit_q    <= 1'b0;
            s2_idx_q    <= '0;
            s2_lxwr_q   <= '0;
            s2_priv_q   <= '0;
            s2_type_q   <= '0;
            s2_ch_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_ch_q    <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (s1_ready) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_addr_q <= req_addr;
                    s1_priv_q <= req_priv;
                    s1_type_q <= req_type;
                    s1_ch_q   <= grant;
                end
            end
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_hit_q  <= win_hit;
                    s2_idx_q  <= win_idx;
                    s2_lxwr_q <= win_lxwr;
                    s2_priv_q <= s1_priv_q;
                    s2_type_q <= s1_type_q;
                    s2_ch_q   <= s1_ch_q;
                end
            end
            if (out_ready) begin
                rsp_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    rsp_fault_q <= s2_fault;
                    rsp_hit_q   <= s2_hit_q;
                    rsp_idx_q   <= s2_idx_q;
                    rsp_ch_q    <= s2_ch_q;
                end
            end
        end
    end

    assign RspValid = rsp_valid_q;
    assign RspFault = rsp_fault_q;
    assign RspHit   = rsp_hit_q;
    assign RspIdx   = rsp_idx_q;
    assign RspCh    = rsp_ch_q;

    logic unused_cfg;
    assign unused_cfg = ^PMPCfg;

`ifdef PMP_FAULT_LOG_EN
    logic [PA_BITS-1:0] s2_addr_q, rsp_addr_q, fault_addr_q;
    logic [15:0]        fault_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_addr_q    <= '0;
            rsp_addr_q   <= '0;
            fault_addr_q <= '0;
            fault_cnt_q  <= '0;
        end else begin
            if (s2_ready && s1_valid_q) s2_addr_q <= s1_addr_q;
            if (out_ready && s2_valid_q) rsp_addr_q <= s2_addr_q;
            if (rsp_valid_q && RspReady && rsp_fault_q) begin
                fault_addr_q <= rsp_addr_q;
                if (fault_cnt_q != 16'hFFFF) fault_cnt_q <= fault_cnt_q + 16'd1;
            end
        end
    end

    assign FaultAddr = fault_addr_q;
    assign FaultCnt  = fault_cnt_q;
`else
    logic unused_lo;
    assign unused_lo = ^s1_addr_q[1:0];
`endif

endmodule

// File: tb/tb_pmp_check_pipe.sv
// Directed self-checking bench for pmp_check_pipe (default parameters, 2 channels, 16 entries).
module tb_pmp_check_pipe;

    localparam int PA = 56;
    localparam int NE = 16;
    localparam int NC = 2;
    localparam int AW = PA - 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     ReqValid, ReqReady;
    logic [NC*PA-1:0]  ReqAddr;
    logic [NC*2-1:0]   ReqPriv, ReqType;
    logic [NE*8-1:0]   PMPCfg;
    logic [NE*AW-1:0]  PMPAdr;
    logic              RspValid, RspReady, RspFault, RspHit;
    logic [0:0]        RspCh;
    logic [5:0]        RspIdx;
`ifdef PMP_FAULT_LOG_EN
    logic [PA-1:0]     FaultAddr;
    logic [15:0]       FaultCnt;
`endif

    int checks = 0;
    int errors = 0;

    pmp_check_pipe dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr),
        .ReqPriv(ReqPriv), .ReqType(ReqType),
        .PMPCfg(PMPCfg), .PMPAdr(PMPAdr),
        .RspValid(RspValid), .RspReady(RspReady), .RspCh(RspCh),
        .RspFault(RspFault), .RspHit(RspHit), .RspIdx(RspIdx)
`ifdef PMP_FAULT_LOG_EN
        , .FaultAddr(FaultAddr), .FaultCnt(FaultCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic set_entry(input int i, input logic [7:0] cfg, input logic [AW-1:0] adr);
        PMPCfg[i*8 +: 8]  = cfg;
        PMPAdr[i*AW +: AW] = adr;
    endtask

    task automatic clear_pmp();
        PMPCfg = '0;
        PMPAdr = '0;
    endtask

    // Present a request on one channel until it is granted; returns at the negedge after acceptance.
    task automatic send(input int ch, input logic [PA-1:0] a, input logic [1:0] p, input logic [1:0] t);
        int n = 0;
        ReqAddr[ch*PA +: PA] = a;
        ReqPriv[ch*2 +: 2]   = p;
        ReqType[ch*2 +: 2]   = t;
        ReqValid[ch]         = 1'b1;
        #1;
        while (ReqReady[ch] !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (ReqReady[ch] !== 1'b1) begin
            checks++; errors++;
            $display("FAIL req_timeout: ReqReady[%0d]=%b after %0d cycles, expected 1", ch, ReqReady[ch], n);
        end
        @(negedge clk);
        ReqValid[ch] = 1'b0;
    endtask

    // Wait (bounded) for a response, capture it, and let it handshake (RspReady held by caller).
    task automatic get_rsp(output logic f, output logic h, output logic [5:0] idx);
        int n = 0;
        #1;
        while (RspValid !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (RspValid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: RspValid=%b after %0d cycles, expected 1", RspValid, n);
        end
        f = RspFault; h = RspHit; idx = RspIdx;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (RspValid !== 1'b0 || RspFault !== 1'b0 || RspHit !== 1'b0 || RspIdx !== 6'd0 || RspCh !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b fault=%b hit=%b idx=%0d ch=%b, expected all 0",
                     RspValid, RspFault, RspHit, RspIdx, RspCh);
        end
        checks++;
        if (ReqReady !== 2'b00) begin
            errors++;
            $display("FAIL reset_reqready: ReqReady=%b, expected 00", ReqReady);
        end
`ifdef PMP_FAULT_LOG_EN
        checks++;
        if (FaultCnt !== 16'd0 || FaultAddr !== '0) begin
            errors++;
            $display("FAIL reset_faultlog: cnt=%0d addr=%h, expected 0 0", FaultCnt, FaultAddr);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_napot();
        logic [PA-1:0] va[4] = '{56'h8000_0FFC, 56'h8000_1000, 56'h8000_0000, 56'h7FFF_FFFC};
        logic          ef[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic          eh[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic f, h;
        logic [5:0] idx;
        clear_pmp();
        set_entry(0, 8'h19, 54'h2000_01FF);
        RspReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(0, va[k], 2'b00, 2'b00);
            get_rsp(f, h, idx);
            checks++;
            if (f !== ef[k] || h !== eh[k] || idx !== 6'd0) begin
                errors++;
                $display("FAIL napot[%0d]: fault=%b hit=%b idx=%0d, expected %b %b 0", k, f, h, idx, ef[k], eh[k]);
            end
        end
    endtask

    task automatic test_tor_na4();
        logic [PA-1:0] va[8] = '{56'h1000, 56'h0FFC, 56'h2000, 56'h2000, 56'h0FFC, 56'h1000, 56'h1000, 56'h0};
        logic [1:0]    vp[8] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [1:0]    vt[8] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
        logic          ef[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic          eh[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [5:0]    ei[8] = '{6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd0};
        logic f, h;
        logic [5:0] idx;
        clear_pmp();
        set_entry(0, 8'h0F, 54'h400);
        set_entry(1, 8'h91, 54'h400);
        RspReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(1, va[k], vp[k], vt[k]);
            get_rsp(f, h, idx);
            checks++;
            if (f !== ef[k] || h !== eh[k] || idx !== ei[k]) begin
                errors++;
                $display("FAIL tor_na4[%0d]: fault=%b hit=%b idx=%0d, expected %b %b %0d",
                         k, f, h, idx, ef[k], eh[k], ei[k]);
            end
        end
    endtask

    task automatic test_boundaries();
        logic f, h;
        logic [5:0] idx;
        RspReady = 1'b1;
        clear_pmp();
        set_entry(0, 8'h19, '1);
        send(0, 56'hFF_FFFF_FFFF_FFFC, 2'b00, 2'b00);
        get_rsp(f, h, idx);
        checks++;
        if (f !== 1'b0 || h !== 1'b1 || idx !== 6'd0) begin
            errors++;
            $display("FAIL napot_all_read: fault=%b hit=%b idx=%0d, expected 0 1 0", f, h, idx);
        end
        send(0, 56'h0, 2'b01, 2'b01);
        get_rsp(f, h, idx);
        checks++;
        if (f !== 1'b1 || h !== 1'b1) begin
            errors++;
            $display("FAIL napot_all_swrite: fault=%b hit=%b, expected 1 1", f, h);
        end
        set_entry(0, 8'h98, '1);
        send(0, 56'h1234_5678, 2'b11, 2'b00);
        get_rsp(f, h, idx);
        checks++;
        if (f !== 1'b1 || h !== 1'b1) begin
            errors++;
            $display("FAIL locked_mmode: fault=%b hit=%b, expected 1 1", f, h);
        end
        clear_pmp();
        set_entry(1, 8'h00, 54'h500);
        set_entry(2, 8'h0F, 54'h400);
        send(0, 56'h1000, 2'b00, 2'b00);
        get_rsp(f, h, idx);
        checks++;
        if (f !== 1'b1 || h !== 1'b0 || idx !== 6'd0) begin
            errors++;
            $display("FAIL tor_inverted: fault=%b hit=%b idx=%0d, expected 1 0 0", f, h, idx);
        end
    endtask

    // Response for a grant sampled at negedge j appears at the sample of negedge j+3.
    task automatic test_round_robin();
        logic [1:0] exp_rdy;
        logic [0:0] exp_ch;
        do_reset();
        clear_pmp();
        RspReady = 1'b1;
        ReqAddr[0 +: PA]  = 56'h100;
        ReqAddr[PA +: PA] = 56'h200;
        ReqPriv = 4'b11_00;
        ReqType = 4'b00_00;
        ReqValid = 2'b11;
        for (int j = 0; j < 10; j++) begin
            #1;
            exp_rdy = (j % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (ReqReady !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant[%0d]: ReqReady=%b, expected %b", j, ReqReady, exp_rdy);
            end
            if (j >= 3) begin
                exp_ch = 1'((j - 3) % 2);
                checks++;
                if (RspValid !== 1'b1 || RspCh !== exp_ch || RspFault !== ~exp_ch) begin
                    errors++;
                    $display("FAIL rr_rsp[%0d]: valid=%b ch=%b fault=%b, expected 1 %b %b",
                             j, RspValid, RspCh, RspFault, exp_ch, ~exp_ch);
                end
            end else begin
                checks++;
                if (RspValid !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_latency[%0d]: RspValid=%b, expected 0", j, RspValid);
                end
            end
            @(negedge clk);
        end
        ReqValid = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int         accepted = 0;
        int         n = 0;
        logic       rdy;
        logic [5:0] got[4];
        clear_pmp();
        for (int k = 0; k < 3; k++) set_entry(k, 8'h11, 54'(32'h100 + k));
        RspReady = 1'b0;
        ReqPriv[1:0] = 2'b00;
        ReqType[1:0] = 2'b00;
        ReqAddr[0 +: PA] = 56'h400;
        ReqValid[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            #1;
            checks++;
            if (j >= 3) begin
                if (RspValid !== 1'b1 || RspIdx !== 6'd0 || RspHit !== 1'b1 || RspFault !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold[%0d]: valid=%b idx=%0d hit=%b fault=%b, expected 1 0 1 0",
                             j, RspValid, RspIdx, RspHit, RspFault);
                end
            end else if (RspValid !== 1'b0) begin
                errors++;
                $display("FAIL bp_early[%0d]: RspValid=%b, expected 0", j, RspValid);
            end
            rdy = ReqReady[0];
            @(negedge clk);
            if (rdy) begin
                accepted++;
                ReqAddr[0 +: PA] = 56'h400 + 56'(4 * accepted);
            end
        end
        ReqValid[0] = 1'b0;
        #1;
        checks++;
        if (accepted != 3) begin
            errors++;
            $display("FAIL bp_accepted: accepted=%0d, expected 3", accepted);
        end
        RspReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (RspValid === 1'b1) begin
                if (n < 4) got[n] = RspIdx;
                n++;
            end
            @(negedge clk); #1;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL bp_count: responses=%0d, expected 3", n);
        end else begin
            checks++;
            if (got[0] !== 6'd0 || got[1] !== 6'd1 || got[2] !== 6'd2) begin
                errors++;
                $display("FAIL bp_order: idx=%0d,%0d,%0d, expected 0,1,2", got[0], got[1], got[2]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_config_change();
        logic f, h;
        logic [5:0] idx;
        clear_pmp();
        set_entry(0, 8'h11, 54'h800);
        RspReady = 1'b1;
        send(0, 56'h2000, 2'b00, 2'b00);
        @(negedge clk);
        set_entry(0, 8'h01, 54'h800);
        get_rsp(f, h, idx);
        checks++;
        if (f !== 1'b0 || h !== 1'b1 || idx !== 6'd0) begin
            errors++;
            $display("FAIL cfg_inflight: fault=%b hit=%b idx=%0d, expected 0 1 0", f, h, idx);
        end
        send(0, 56'h2000, 2'b00, 2'b00);
        get_rsp(f, h, idx);
        checks++;
        if (f !== 1'b1 || h !== 1'b0) begin
            errors++;
            $display("FAIL cfg_after: fault=%b hit=%b, expected 1 0", f, h);
        end
    endtask

    task automatic test_reset_inflight();
        int n = 0;
`ifdef PMP_FAULT_LOG_EN
        logic f, h;
        logic [5:0] idx;
`endif
        clear_pmp();
        RspReady = 1'b0;
        ReqAddr[0 +: PA] = 56'h3000;
        ReqPriv[1:0] = 2'b00;
        ReqType[1:0] = 2'b00;
        ReqValid[0] = 1'b1;
        repeat (6) @(negedge clk);
        ReqValid[0] = 1'b0;
        #1;
        checks++;
        if (RspValid !== 1'b1 || RspFault !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: valid=%b fault=%b, expected 1 1", RspValid, RspFault);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (RspValid !== 1'b0 || RspFault !== 1'b0 || RspHit !== 1'b0 || RspIdx !== 6'd0 || RspCh !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: valid=%b fault=%b hit=%b idx=%0d ch=%b, expected all 0",
                     RspValid, RspFault, RspHit, RspIdx, RspCh);
        end
        @(negedge clk);
        reset = 1'b0;
        RspReady = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk); #1;
            if (RspValid === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL rst_no_rsp: responses=%0d, expected 0", n);
        end
        @(negedge clk);
`ifdef PMP_FAULT_LOG_EN
        checks++;
        if (FaultCnt !== 16'd0) begin
            errors++;
            $display("FAIL log_rst: FaultCnt=%0d, expected 0", FaultCnt);
        end
        send(0, 56'h5000, 2'b00, 2'b00);
        get_rsp(f, h, idx);
        checks++;
        if (FaultCnt !== 16'd1 || FaultAddr !== 56'h5000) begin
            errors++;
            $display("FAIL log_one: cnt=%0d addr=%h, expected 1 5000", FaultCnt, FaultAddr);
        end
        send(1, 56'h6000, 2'b01, 2'b01);
        get_rsp(f, h, idx);
        send(0, 56'h7000, 2'b11, 2'b00);
        get_rsp(f, h, idx);
        checks++;
        if (FaultCnt !== 16'd2 || FaultAddr !== 56'h6000) begin
            errors++;
            $display("FAIL log_two: cnt=%0d addr=%h, expected 2 6000", FaultCnt, FaultAddr);
        end
`endif
    endtask

    initial begin
        reset    = 1'b1;
        ReqValid = '0;
        ReqAddr  = '0;
        ReqPriv  = '0;
        ReqType  = '0;
        RspReady = 1'b1;
        PMPCfg   = '0;
        PMPAdr   = '0;
        @(negedge clk);
        test_reset();
        test_napot();
        test_tor_na4();
        test_boundaries();
        test_round_robin();
        test_backpressure();
        test_config_change();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
